// File: rtl/rtr_port_driver_pkg.sv
// Shared types and frame geometry for the router port driver.
package rtr_port_driver_pkg;

   localparam int unsigned ADDR_BITS    = 4;
   localparam int unsigned PAYLOAD_BITS = 32;
   localparam int unsigned FRAME_BITS   = ADDR_BITS + PAYLOAD_BITS;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData,
      StGap
   } tx_state_e;

endpackage

// File: rtl/rtr_pkt_fifo.sv
// Packet buffer with registered full/empty flags; same-cycle push and pop allowed.
module rtr_pkt_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 36
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             do_push, do_pop;

   // Gating on the registered flags means a full FIFO never accepts, even alongside a pop.
   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (do_pop && !do_push) count_d = count_q - CntW'(1);
      full_d  = (count_d == CntW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/rtr_port_driver.sv
// Host-side bit-serial transmitter: buffers {addr,payload} packets and emits
// frame_n/valid_n/di frames, LSB first, address before payload.
module rtr_port_driver
   import rtr_port_driver_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_BITS-1:0]    in_addr,
   input  logic [PAYLOAD_BITS-1:0] in_payload,
   input  logic                    hold,
   output logic                    frame_n,
   output logic                    valid_n,
   output logic                    di,
   output logic                    busy,
   output logic [15:0]             tx_count
);

   tx_state_e             state_q, state_d;
   logic [FRAME_BITS-1:0] sr_q, sr_d;
   logic [5:0]            bit_cnt_q, bit_cnt_d;
   logic [3:0]            gap_cnt_q, gap_cnt_d;
   logic                  frame_n_q, frame_n_d;
   logic                  valid_n_q, valid_n_d;
   logic                  di_q, di_d;
   logic [15:0]           tx_count_q, tx_count_d;
   logic                  pop;
   logic [FRAME_BITS-1:0] fifo_rdata;
   logic                  fifo_full, fifo_empty;

   rtr_pkt_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FRAME_BITS)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (in_valid),
      .wdata_i ({in_payload, in_addr}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // bit_cnt_q counts bits already placed on di in the current frame.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      frame_n_d  = 1'b1;
      valid_n_d  = 1'b1;
      di_d       = 1'b0;
      tx_count_d = tx_count_q;
      pop        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty && !hold) begin
               pop       = 1'b1;
               state_d   = StAddr;
               sr_d      = fifo_rdata >> 1;
               di_d      = fifo_rdata[0];
               frame_n_d = 1'b0;
               bit_cnt_d = 6'd1;
            end
         end
         StAddr, StData: begin
            if (bit_cnt_q == 6'(FRAME_BITS)) begin
               state_d    = StGap;
               gap_cnt_d  = 4'd1;
               tx_count_d = tx_count_q + 16'd1;
            end else begin
               di_d      = sr_q[0];
               sr_d      = sr_q >> 1;
               bit_cnt_d = bit_cnt_q + 6'd1;
               // The last payload bit carries frame_n high as the end-of-frame marker.
               frame_n_d = (bit_cnt_q == 6'(FRAME_BITS - 1));
               valid_n_d = (bit_cnt_q < 6'(ADDR_BITS));
               state_d   = (bit_cnt_q < 6'(ADDR_BITS)) ? StAddr : StData;
            end
         end
         StGap: begin
            if (gap_cnt_q == 4'(GAP)) state_d = StIdle;
            else                      gap_cnt_d = gap_cnt_q + 4'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         frame_n_q  <= 1'b1;
         valid_n_q  <= 1'b1;
         di_q       <= 1'b0;
         tx_count_q <= '0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         frame_n_q  <= frame_n_d;
         valid_n_q  <= valid_n_d;
         di_q       <= di_d;
         tx_count_q <= tx_count_d;
      end
   end

   assign in_ready = ~fifo_full;
   assign frame_n  = frame_n_q;
   assign valid_n  = valid_n_q;
   assign di       = di_q;
   assign busy     = (state_q != StIdle);
   assign tx_count = tx_count_q;

endmodule

// File: tb/tb_rtr_port_driver.sv
// Self-checking bench: every negedge sample of the serial lines is logged and
// decoded frames are compared with frames built from the packet-level rules.
module tb_rtr_port_driver;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned GAP   = 2;
   localparam int FLEN = 36;
   localparam int SLOT = FLEN + GAP + 1;

   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] p;
   } pkt_t;

   logic        clock, reset_n, in_valid, in_ready, hold;
   logic        frame_n, valid_n, di, busy;
   logic [3:0]  in_addr;
   logic [31:0] in_payload;
   logic [15:0] tx_count;

   int          errors, checks;
   logic [15:0] exp_tx;
   logic [2:0]  trace[$];
   pkt_t        model_q[$];

   rtr_port_driver #(
      .DEPTH (DEPTH),
      .GAP   (GAP)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_addr    (in_addr),
      .in_payload (in_payload),
      .hold       (hold),
      .frame_n    (frame_n),
      .valid_n    (valid_n),
      .di         (di),
      .busy       (busy),
      .tx_count   (tx_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) trace.push_back({frame_n, valid_n, di});

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   function automatic pkt_t rand_pkt();
      pkt_t r;
      r.a = 4'($urandom);
      r.p = $urandom;
      return r;
   endfunction

   task automatic drive(input pkt_t p);
      in_valid   = 1'b1;
      in_addr    = p.a;
      in_payload = p.p;
   endtask

   // Frame rule: 4 address bits with valid_n high, then 32 payload bits with
   // valid_n low, LSB first; frame_n low throughout except on the final bit.
   function automatic void expect_frame(input pkt_t p, output logic [35:0] fn,
                                        output logic [35:0] vn, output logic [35:0] dd);
      for (int i = 0; i < FLEN; i++) begin
         fn[i] = (i == FLEN - 1);
         if (i < 4) begin
            vn[i] = 1'b1;
            dd[i] = p.a[i];
         end else begin
            vn[i] = 1'b0;
            dd[i] = p.p[i-4];
         end
      end
   endfunction

   function automatic int find_frame(input int start);
      for (int i = start; i < trace.size(); i++) begin
         if (trace[i][2] == 1'b0) return i;
      end
      return -1;
   endfunction

   function automatic void get_frame(input int s, output logic [35:0] fn,
                                     output logic [35:0] vn, output logic [35:0] dd);
      for (int i = 0; i < FLEN; i++) begin
         if (s >= 0 && s + i < trace.size()) {fn[i], vn[i], dd[i]} = trace[s+i];
         else {fn[i], vn[i], dd[i]} = 3'bxxx;
      end
   endfunction

   function automatic int count_bad_idle(input int from, input int to);
      int n = 0;
      for (int i = from; i < to && i < trace.size(); i++) begin
         if (trace[i] !== 3'b110) n++;
      end
      return n;
   endfunction

   function automatic int count_low(input int from);
      int n = 0;
      for (int i = from; i < trace.size(); i++) begin
         if (trace[i][2] !== 1'b1) n++;
      end
      return n;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; hold = 1'b0; in_addr = '0; in_payload = '0;
      step(2);
      checks++; if (frame_n !== 1'b1) begin errors++; $display("FAIL reset_frame_n: got %b expected 1", frame_n); end
      checks++; if (valid_n !== 1'b1) begin errors++; $display("FAIL reset_valid_n: got %b expected 1", valid_n); end
      checks++; if (di !== 1'b0) begin errors++; $display("FAIL reset_di: got %b expected 0", di); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (tx_count !== 16'd0) begin errors++; $display("FAIL reset_tx_count: got %h expected 0", tx_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      reset_n = 1'b1;
      exp_tx = '0;
      model_q.delete();
      step(1);
   endtask

   task automatic test_single();
      pkt_t p;
      int s;
      logic [35:0] fn, vn, dd, efn, evn, edd;
      p.a = 4'h5; p.p = 32'hA5A5_0F0F;
      trace.delete();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
      drive(p);
      step(1);
      in_valid = 1'b0;
      checks++; if (frame_n !== 1'b1) begin errors++; $display("FAIL single_no_bypass: got frame_n=%b expected 1", frame_n); end
      step(44);
      s = find_frame(0);
      checks++; if (s != 2) begin errors++; $display("FAIL single_first_bit: got sample %0d expected 2", s); end
      get_frame(s, fn, vn, dd);
      expect_frame(p, efn, evn, edd);
      checks++; if (fn !== efn) begin errors++; $display("FAIL single_frame_n: got %h expected %h", fn, efn); end
      checks++; if (vn !== evn) begin errors++; $display("FAIL single_valid_n: got %h expected %h", vn, evn); end
      checks++; if (dd !== edd) begin errors++; $display("FAIL single_di: got %h expected %h", dd, edd); end
      exp_tx = exp_tx + 16'd1;
      checks++; if (tx_count !== exp_tx) begin errors++; $display("FAIL single_tx_count: got %0d expected %0d", tx_count, exp_tx); end
   endtask

   task automatic test_back_to_back();
      pkt_t p;
      int s, s_prev, start;
      logic [35:0] fn, vn, dd, efn, evn, edd;
      trace.delete();
      for (int k = 0; k < 3; k++) begin
         p = rand_pkt();
         model_q.push_back(p);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1 at push %0d", in_ready, k); end
         drive(p);
         step(1);
      end
      in_valid = 1'b0;
      step(3 * SLOT + 5);
      s_prev = -1; start = 0;
      for (int k = 0; k < 3; k++) begin
         s = find_frame(start);
         get_frame(s, fn, vn, dd);
         p = model_q.pop_front();
         expect_frame(p, efn, evn, edd);
         checks++; if ({fn, vn, dd} !== {efn, evn, edd}) begin errors++; $display("FAIL b2b_frame%0d: got %h/%h/%h expected %h/%h/%h", k, fn, vn, dd, efn, evn, edd); end
         if (k == 0) begin
            checks++; if (s != 2) begin errors++; $display("FAIL b2b_first_bit: got sample %0d expected 2", s); end
         end else begin
            checks++; if (s - (s_prev + FLEN) != int'(GAP) + 1) begin errors++; $display("FAIL b2b_gap%0d: got %0d idle cycles expected %0d", k, s - (s_prev + FLEN), GAP + 1); end
            checks++; if (count_bad_idle(s_prev + FLEN, s) != 0) begin errors++; $display("FAIL b2b_idle_lines%0d: got %0d bad samples expected 0", k, count_bad_idle(s_prev + FLEN, s)); end
         end
         s_prev = s;
         start = s + FLEN;
      end
      exp_tx = exp_tx + 16'd3;
      checks++; if (tx_count !== exp_tx) begin errors++; $display("FAIL b2b_tx_count: got %0d expected %0d", tx_count, exp_tx); end
   endtask

   task automatic test_full();
      pkt_t p;
      int s, start;
      logic [35:0] fn, vn, dd, efn, evn, edd;
      hold = 1'b1;
      trace.delete();
      for (int i = 0; i < 6; i++) begin
         p = rand_pkt();
         checks++; if (in_ready !== (model_q.size() < DEPTH)) begin errors++; $display("FAIL full_in_ready%0d: got %b expected %b", i, in_ready, model_q.size() < DEPTH); end
         if (model_q.size() < DEPTH) model_q.push_back(p);
         drive(p);
         step(1);
      end
      in_valid = 1'b0;
      step(4);
      checks++; if (count_low(0) != 0) begin errors++; $display("FAIL full_hold_idle: got %0d frame samples expected 0", count_low(0)); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_held: got %b expected 0", in_ready); end
      hold = 1'b0;
      trace.delete();
      step(4 * SLOT + 5);
      start = 0;
      for (int k = 0; k < 4; k++) begin
         s = find_frame(start);
         get_frame(s, fn, vn, dd);
         p = model_q.pop_front();
         expect_frame(p, efn, evn, edd);
         checks++; if ({fn, vn, dd} !== {efn, evn, edd}) begin errors++; $display("FAIL full_order%0d: got di=%h expected di=%h", k, dd, edd); end
         start = (s < 0) ? trace.size() : s + FLEN;
      end
      checks++; if (find_frame(start) != -1) begin errors++; $display("FAIL full_extra_frame: got frame at %0d expected none", find_frame(start)); end
      exp_tx = exp_tx + 16'd4;
      checks++; if (tx_count !== exp_tx) begin errors++; $display("FAIL full_tx_count: got %0d expected %0d", tx_count, exp_tx); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_drained: got %b expected 1", in_ready); end
   endtask

   task automatic test_hold();
      pkt_t p;
      int s;
      logic [35:0] fn, vn, dd, efn, evn, edd;
      trace.delete();
      p = rand_pkt();
      drive(p);
      step(1);
      in_valid = 1'b0;
      step(15);
      checks++; if ({frame_n, valid_n} !== 2'b00) begin errors++; $display("FAIL hold_mid_in_data: got %b expected 00", {frame_n, valid_n}); end
      hold = 1'b1;
      step(30);
      s = find_frame(0);
      get_frame(s, fn, vn, dd);
      expect_frame(p, efn, evn, edd);
      checks++; if ({fn, vn} !== {efn, evn}) begin errors++; $display("FAIL hold_mid_framing: got %h/%h expected %h/%h", fn, vn, efn, evn); end
      checks++; if (dd !== edd) begin errors++; $display("FAIL hold_mid_di: got %h expected %h", dd, edd); end
      exp_tx = exp_tx + 16'd1;
      checks++; if (tx_count !== exp_tx) begin errors++; $display("FAIL hold_mid_tx_count: got %0d expected %0d", tx_count, exp_tx); end
      trace.delete();
      p = rand_pkt();
      drive(p);
      step(1);
      in_valid = 1'b0;
      step(10);
      checks++; if (count_low(0) != 0) begin errors++; $display("FAIL hold_idle_blocks: got %0d frame samples expected 0", count_low(0)); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle_busy: got %b expected 0", busy); end
      hold = 1'b0;
      trace.delete();
      step(40);
      s = find_frame(0);
      checks++; if (s != 1) begin errors++; $display("FAIL hold_release_start: got sample %0d expected 1", s); end
      get_frame(s, fn, vn, dd);
      expect_frame(p, efn, evn, edd);
      checks++; if (dd !== edd) begin errors++; $display("FAIL hold_release_di: got %h expected %h", dd, edd); end
      exp_tx = exp_tx + 16'd1;
   endtask

   task automatic test_reset_mid();
      pkt_t p1, p2, p3;
      // Abort during address bit 2 of the first frame, second packet queued.
      trace.delete();
      p1 = rand_pkt(); p2 = rand_pkt();
      drive(p1); step(1);
      drive(p2); step(1);
      in_valid = 1'b0;
      step(2);
      checks++; if ({frame_n, valid_n, di} !== {2'b01, p1.a[2]}) begin errors++; $display("FAIL rst_addr_pre: got %b expected %b", {frame_n, valid_n, di}, {2'b01, p1.a[2]}); end
      reset_n = 1'b0;
      #1;
      exp_tx = '0;
      checks++; if ({frame_n, valid_n, di} !== 3'b110) begin errors++; $display("FAIL rst_addr_lines: got %b expected 110", {frame_n, valid_n, di}); end
      checks++; if (tx_count !== exp_tx) begin errors++; $display("FAIL rst_addr_tx_count: got %0d expected 0", tx_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_addr_in_ready: got %b expected 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_addr_busy: got %b expected 0", busy); end
      step(1);
      reset_n = 1'b1;
      trace.delete();
      step(45);
      checks++; if (count_low(0) != 0) begin errors++; $display("FAIL rst_addr_discard: got %0d frame samples expected 0", count_low(0)); end
      // Abort during payload bit 20 of the second frame, third packet queued.
      trace.delete();
      p1 = rand_pkt(); p2 = rand_pkt(); p3 = rand_pkt();
      drive(p1); step(1);
      drive(p2); step(1);
      drive(p3); step(1);
      in_valid = 1'b0;
      step(62);
      checks++; if (tx_count !== 16'd1) begin errors++; $display("FAIL rst_data_pre_tx: got %0d expected 1", tx_count); end
      checks++; if ({frame_n, valid_n, di} !== {2'b00, p2.p[20]}) begin errors++; $display("FAIL rst_data_pre: got %b expected %b", {frame_n, valid_n, di}, {2'b00, p2.p[20]}); end
      reset_n = 1'b0;
      #1;
      checks++; if ({frame_n, valid_n, di} !== 3'b110) begin errors++; $display("FAIL rst_data_lines: got %b expected 110", {frame_n, valid_n, di}); end
      checks++; if (tx_count !== exp_tx) begin errors++; $display("FAIL rst_data_tx_count: got %0d expected 0", tx_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_data_in_ready: got %b expected 1", in_ready); end
      step(1);
      reset_n = 1'b1;
      trace.delete();
      step(45);
      checks++; if (count_low(0) != 0) begin errors++; $display("FAIL rst_data_discard: got %0d frame samples expected 0", count_low(0)); end
      model_q.delete();
   endtask

   task automatic test_random();
      pkt_t p;
      int s, s_prev, start, issued, guard, n;
      logic [35:0] fn, vn, dd, efn, evn, edd;
      n = 6; issued = 0; guard = 0;
      trace.delete();
      while (issued < n && guard < 400) begin
         hold = ($urandom_range(0, 3) == 0);
         if (in_ready === 1'b1 && $urandom_range(0, 1) == 1) begin
            p = rand_pkt();
            model_q.push_back(p);
            drive(p);
            issued++;
         end else begin
            in_valid = 1'b0;
         end
         step(1);
         guard++;
      end
      in_valid = 1'b0;
      hold = 1'b0;
      step(n * SLOT + 10);
      checks++; if (issued != n) begin errors++; $display("FAIL random_all_issued: got %0d expected %0d", issued, n); end
      s_prev = -1; start = 0;
      for (int k = 0; k < issued; k++) begin
         s = find_frame(start);
         get_frame(s, fn, vn, dd);
         p = model_q.pop_front();
         expect_frame(p, efn, evn, edd);
         checks++; if ({fn, vn, dd} !== {efn, evn, edd}) begin errors++; $display("FAIL random_frame%0d: got di=%h expected di=%h", k, dd, edd); end
         if (k > 0) begin
            checks++; if (s - (s_prev + FLEN) < int'(GAP) + 1) begin errors++; $display("FAIL random_spacing%0d: got %0d expected >= %0d", k, s - (s_prev + FLEN), GAP + 1); end
         end
         s_prev = s;
         start = (s < 0) ? trace.size() : s + FLEN;
      end
      exp_tx = exp_tx + 16'(issued);
      checks++; if (tx_count !== exp_tx) begin errors++; $display("FAIL random_tx_count: got %0d expected %0d", tx_count, exp_tx); end
   endtask

   task automatic test_wrap();
      pkt_t p;
      force dut.tx_count_q = 16'hFFFF;
      step(1);
      release dut.tx_count_q;
      step(1);
      checks++; if (tx_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", tx_count); end
      p = rand_pkt();
      drive(p);
      step(1);
      in_valid = 1'b0;
      step(44);
      exp_tx = 16'h0000;
      checks++; if (tx_count !== exp_tx) begin errors++; $display("FAIL wrap_tx_count: got %h expected 0000", tx_count); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      exp_tx = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_hold();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
